// File: rtl/regfile_pkg.sv
// Integer register file constants and the operand_fetch FSM state type.
// RETRY is present only when OPERAND_FETCH_BYPASS_EN is undefined.
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

`ifdef OPERAND_FETCH_BYPASS_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } opf_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    HOLD  = 2'd2,
    RETRY = 2'd3
  } opf_state_t;
`endif
endpackage

// File: rtl/operand_fwd_slot.sv
// One source operand: latched index, captured value and writeback collision compare.
// With OPERAND_FETCH_BYPASS_EN the slot also forwards writeback data into the value.
module operand_fwd_slot
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  capture,
  input  logic                  track,
  input  logic [REG_ADDR_W-1:0] in_idx,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  hit,
  output logic [REG_ADDR_W-1:0] idx,
  output logic [DATA_W-1:0]     value
);
  logic [REG_ADDR_W-1:0] idx_q;
  logic [REG_ADDR_W-1:0] cmp_idx;

  // While loading, the incoming index is the one the writeback can collide with.
  assign cmp_idx = load ? in_idx : idx_q;
  assign hit     = wb_en && (cmp_idx != REG_ZERO) && (wb_rd == cmp_idx);
  assign idx     = idx_q;

`ifdef OPERAND_FETCH_BYPASS_EN
  logic              pend_q;
  logic [DATA_W-1:0] pend_data_q;
  logic              unused_track;

  assign unused_track = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q       <= '0;
      value       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
    end else if (load) begin
      idx_q       <= in_idx;
      pend_q      <= hit;
      pend_data_q <= wb_data;
    end else if (capture) begin
      // Newest write wins: READ-cycle write beats one caught at accept.
      pend_q <= 1'b0;
      if (idx_q == REG_ZERO)  value <= '0;
      else if (hit)           value <= wb_data;
      else if (pend_q)        value <= pend_data_q;
      else                    value <= rf_data;
    end else if (track && hit) begin
      value <= wb_data;
    end
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{track, wb_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      value <= '0;
    end else if (load) begin
      idx_q <= in_idx;
    end else if (capture) begin
      value <= (idx_q == REG_ZERO) ? '0 : rf_data;
    end
  end
`endif
endmodule

// File: rtl/operand_fetch.sv
// Register-file read client between decode and execute with writeback snooping.
// OPERAND_FETCH_BYPASS_EN selects forwarding; otherwise collisions re-read via RETRY.
module operand_fetch #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [regfile_pkg::REG_ADDR_W-1:0]  in_rs1,
  input  logic [regfile_pkg::REG_ADDR_W-1:0]  in_rs2,
  input  logic [TAG_W-1:0]                    in_tag,
  output logic                                rf_r_en,
  output logic [regfile_pkg::REG_ADDR_W-1:0]  rf_r1,
  output logic [regfile_pkg::REG_ADDR_W-1:0]  rf_r2,
  input  logic [XLEN-1:0]                     rf_r1_read,
  input  logic [XLEN-1:0]                     rf_r2_read,
  input  logic                                wb_en,
  input  logic [regfile_pkg::REG_ADDR_W-1:0]  wb_rd,
  input  logic [XLEN-1:0]                     wb_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [XLEN-1:0]                     out_op1,
  output logic [XLEN-1:0]                     out_op2,
  output logic [TAG_W-1:0]                    out_tag,
  output regfile_pkg::opf_state_t             fsm_state
);
  import regfile_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and held outputs only change after transfer
  // (or, with bypass, when a writeback refreshes a held operand in place).
  opf_state_t state_q, state_d;
  logic accept, capture, track, hit1, hit2;
  logic [REG_ADDR_W-1:0] idx1, idx2;
  logic [TAG_W-1:0] tag_q;

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign out_tag   = tag_q;
  assign fsm_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef OPERAND_FETCH_BYPASS_EN
  logic unused_hits;
  assign unused_hits = hit1 ^ hit2;
`else
  // A write in the accept or RETRY cycle makes the pending read stale.
  logic stale_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                           stale_q <= 1'b0;
    else if (accept || state_q == RETRY)  stale_q <= hit1 || hit2;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = READ;
`ifdef OPERAND_FETCH_BYPASS_EN
      READ: state_d = HOLD;
`else
      READ:  state_d = (stale_q || hit1 || hit2) ? RETRY : HOLD;
      RETRY: state_d = READ;
`endif
      HOLD: begin
        if (out_ready)       state_d = accept ? READ : IDLE;
`ifndef OPERAND_FETCH_BYPASS_EN
        else if (hit1 || hit2) state_d = RETRY;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    rf_r_en  = 1'b0;
    rf_r1    = '0;
    rf_r2    = '0;
    capture  = 1'b0;
    track    = 1'b0;
    if (rst_n) begin
      in_ready = (state_q == IDLE) || (state_q == HOLD && out_ready);
      capture  = (state_q == READ);
      track    = (state_q == HOLD);
      if (in_valid && in_ready) begin
        rf_r_en = 1'b1;
        rf_r1   = in_rs1;
        rf_r2   = in_rs2;
      end
`ifndef OPERAND_FETCH_BYPASS_EN
      else if (state_q == RETRY) begin
        rf_r_en = 1'b1;
        rf_r1   = idx1;
        rf_r2   = idx2;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      tag_q <= '0;
    else if (accept) tag_q <= in_tag;
  end

  operand_fwd_slot #(.DATA_W(XLEN)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .capture (capture),
    .track   (track),
    .in_idx  (in_rs1),
    .rf_data (rf_r1_read),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .hit     (hit1),
    .idx     (idx1),
    .value   (out_op1)
  );

  operand_fwd_slot #(.DATA_W(XLEN)) u_slot2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .capture (capture),
    .track   (track),
    .in_idx  (in_rs2),
    .rf_data (rf_r2_read),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .hit     (hit2),
    .idx     (idx2),
    .value   (out_op2)
  );
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register file model, vector table, corner sequences,
// random traffic and a scoreboard checking every operand transfer.
module tb_operand_fetch;
  import regfile_pkg::*;

  localparam int W  = 32;
  localparam int TW = 8;
`ifdef OPERAND_FETCH_BYPASS_EN
  localparam int LAT_COL = 2;
`else
  localparam int LAT_COL = 4;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready;
  logic [4:0] in_rs1, in_rs2;
  logic [TW-1:0] in_tag;
  logic rf_r_en;
  logic [4:0] rf_r1, rf_r2;
  logic [W-1:0] rf_r1_read, rf_r2_read;
  logic wb_en;
  logic [4:0] wb_rd;
  logic [W-1:0] wb_data;
  logic out_valid, out_ready;
  logic [W-1:0] out_op1, out_op2;
  logic [TW-1:0] out_tag;
  opf_state_t fsm_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(W), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_tag     (in_tag),
    .rf_r_en    (rf_r_en),
    .rf_r1      (rf_r1),
    .rf_r2      (rf_r2),
    .rf_r1_read (rf_r1_read),
    .rf_r2_read (rf_r2_read),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op1    (out_op1),
    .out_op2    (out_op2),
    .out_tag    (out_tag),
    .fsm_state  (fsm_state)
  );

  // Register file: 1-cycle registered read, write lands at the same edge (x0 stored too).
  logic [W-1:0] rf [32] = '{default: '0};
  always @(posedge clk) begin
    if (rf_r_en) begin
      rf_r1_read <= rf[rf_r1];
      rf_r2_read <= rf[rf_r2];
    end
    if (wb_en) rf[wb_rd] <= wb_data;
  end

  function automatic logic [W-1:0] model(input logic [4:0] i);
    return (i == 5'd0) ? '0 : rf[i];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: tags and source indices queued at accept, checked at transfer.
  logic [TW-1:0] exp_q[$];
  logic [9:0]    idx_q[$];
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      idx_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_spurious_transfer", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [TW-1:0] t;
          logic [9:0] p;
          t = exp_q.pop_front();
          p = idx_q.pop_front();
          check("sb_tag", 32'(out_tag), 32'(t));
          check("sb_op1", out_op1, model(p[9:5]));
          check("sb_op2", out_op2, model(p[4:0]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_tag);
        idx_q.push_back({in_rs1, in_rs2});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [W-1:0] data);
    wb_en = 1'b1; wb_rd = rd; wb_data = data;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic wait_valid(inout int lat);
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Returns at the first cycle with out_valid; lat counts cycles from accept.
  task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic [TW-1:0] tag,
                      input logic wen, input logic [4:0] wrd, input logic [W-1:0] wdata,
                      output int lat);
    int n;
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_tag = tag;
    wb_en = wen; wb_rd = wrd; wb_data = wdata;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0; wb_en = 1'b0;
    lat = 1;
    wait_valid(lat);
  endtask

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wen;
    logic [4:0]  wrd;
    logic [W-1:0] wdata;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    int          lat;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int lat;
    logic [TW-1:0] tag;

    // x5=0x11 x6=0x22 x7=0x33 x9=0x99, x0 holds garbage in the RF model.
    vecs[0] = '{5'd5, 5'd6, 1'b0, 5'd0, 32'h0,        32'h11, 32'h22, 2};
    vecs[1] = '{5'd6, 5'd5, 1'b0, 5'd0, 32'h0,        32'h22, 32'h11, 2};
    vecs[2] = '{5'd5, 5'd6, 1'b1, 5'd5, 32'hAB,       32'hAB, 32'h22, LAT_COL};
    vecs[3] = '{5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0,  32'h0,  2};
    vecs[4] = '{5'd7, 5'd7, 1'b1, 5'd7, 32'h55,       32'h55, 32'h55, LAT_COL};
    vecs[5] = '{5'd9, 5'd0, 1'b0, 5'd0, 32'h0,        32'h99, 32'h0,  2};
    vecs[6] = '{5'd6, 5'd9, 1'b1, 5'd3, 32'h77,       32'h22, 32'h99, 2};
    vecs[7] = '{5'd3, 5'd5, 1'b0, 5'd0, 32'h0,        32'h77, 32'hAB, 2};

    // Reset with a request pending on the input.
    rst_n = 1'b0; in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_tag = 8'h5A;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_rf_r_en", 32'(rf_r_en), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0; rst_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_state", 32'(fsm_state), 32'(IDLE));
    check("idle_op1", out_op1, 32'h0);
    check("idle_tag", 32'(out_tag), 32'h0);

    wb_write(5'd5, 32'h11);
    wb_write(5'd6, 32'h22);
    wb_write(5'd7, 32'h33);
    wb_write(5'd9, 32'h99);
    wb_write(5'd0, 32'hFFFF_FFFF);
    tick();

    foreach (vecs[i]) begin
      send(vecs[i].rs1, vecs[i].rs2, 8'(i + 16), vecs[i].wen, vecs[i].wrd, vecs[i].wdata, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_op1", i), out_op1, vecs[i].e1);
      check($sformatf("vec%0d_op2", i), out_op2, vecs[i].e2);
      tick();
    end

    // Back-to-back: second request accepted on the handshake cycle.
    send(5'd5, 5'd6, 8'hA1, 1'b0, 5'd0, 32'h0, lat);
    check("b2b_lat1", 32'(lat), 32'd2);
    check("b2b_op1_first", out_op1, 32'hAB);
    in_valid = 1'b1; in_rs1 = 5'd6; in_rs2 = 5'd5; in_tag = 8'hA2;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    check("b2b_rf_r_en", 32'(rf_r_en), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    wait_valid(lat);
    check("b2b_lat2", 32'(lat), 32'd2);
    check("b2b_op1", out_op1, 32'h22);
    check("b2b_op2", out_op2, 32'hAB);
    tick();

    // Write x6 in READ, then again in HOLD while execute stalls.
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_tag = 8'hC3;
    #1;
    tick();
    in_valid = 1'b0;
    wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h1;
    tick();
    wb_en = 1'b0;
    lat = 2;
    wait_valid(lat);
    check("rdwr_lat", 32'(lat), 32'(LAT_COL));
    check("rdwr_op2", out_op2, 32'h1);
    check("rdwr_op1", out_op1, 32'hAB);
    check("rdwr_tag", 32'(out_tag), 32'hC3);
    wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h2;
    tick();
    wb_en = 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
    check("hold_valid_kept", 32'(out_valid), 32'd1);
`else
    check("hold_valid_dropped", 32'(out_valid), 32'd0);
`endif
    lat = 0;
    wait_valid(lat);
    check("hold_op2", out_op2, 32'h2);
    check("hold_tag", 32'(out_tag), 32'hC3);
    out_ready = 1'b1;
    tick();

    // Reset during READ drops the request.
    in_valid = 1'b1; in_rs1 = 5'd9; in_rs2 = 5'd5; in_tag = 8'h3C;
    #1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_rf_r_en", 32'(rf_r_en), 32'd0);
    check("mid_rst_op1", out_op1, 32'h0);
    check("mid_rst_op2", out_op2, 32'h0);
    check("mid_rst_tag", 32'(out_tag), 32'h0);
    check("mid_rst_rf_r1", 32'(rf_r1), 32'h0);
    rst_n = 1'b1;
    tick();
    send(5'd9, 5'd5, 8'h3D, 1'b0, 5'd0, 32'h0, lat);
    check("post_rst_lat", 32'(lat), 32'd2);
    check("post_rst_op1", out_op1, 32'h99);
    check("post_rst_op2", out_op2, 32'hAB);
    tick();

    // Random traffic with writeback noise and execute back-pressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_rs1    = 5'($urandom_range(0, 7));
      in_rs2    = 5'($urandom_range(0, 7));
      in_tag    = 8'($urandom_range(0, 255));
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    repeat (10) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(fsm_state), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Read-side client of the integer register file. Accepts decoded register-read requests from decode through a valid/ready handshake and drives the register file read port (address pair plus read enable, 1-cycle registered read data). Snoops the writeback bus that drives the register file write port, and hands a consistent operand pair to execute through a second valid/ready handshake. The block sits between decode and execute.

## Interface
- `XLEN`, 32: data width; must match the register file.
- `TAG_W`, 8: opaque sideband width (instruction id/opcode bits), passed through unchanged.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when both are high.
- `in_rs1`, `in_rs2` in 5: source register indices.
- `in_tag` in TAG_W: sideband.
- `rf_r_en` out 1: register file read enable.
- `rf_r1`, `rf_r2` out 5: register file read addresses.
- `rf_r1_read`, `rf_r2_read` in XLEN: register file read data; valid the cycle after `rf_r_en`.
- `wb_en` in 1, `wb_rd` in 5, `wb_data` in XLEN: writeback bus, identical to the register file write port and never stalled.
- `out_valid` out 1, `out_ready` in 1: operand handshake to execute.
- `out_op1`, `out_op2` out XLEN; `out_tag` out TAG_W: operands and sideband.

## Operation
- FSM states are IDLE, READ, HOLD, and RETRY. RETRY exists only when bypass is disabled.
- `in_ready` = (state==IDLE) or (state==HOLD and `out_ready`). `in_ready` is 0 while `rst_n` is low.
- **Accept (cycle N):**
  - `rf_r_en`=1; `rf_r1`/`rf_r2` are driven combinationally from `in_rs1`/`in_rs2`.
  - Indices and tag are latched.
  - Next state is READ.
- **READ (cycle N+1):**
  - Operands are captured from `rf_r*_read`, with forwarding applied.
  - `out_valid` rises in N+2.
  - Next state is HOLD.
- **HOLD:**
  - Outputs are stable while `out_valid` is high and `out_ready` is low.
  - On `out_ready`, the transfer completes. The state goes to READ if a new request is accepted in the same cycle; otherwise it goes to IDLE.
- **Collision definition:** `wb_en` high with `wb_rd` equal to a latched source index, and the index is non-zero. A collision is checked in the accept cycle, the READ cycle, and every HOLD cycle. A write in the accept cycle lands at the same edge as the register file read, so the read returns the stale value.
- **Forwarding:**
  - The newest write wins. A write in READ overrides a pending forward captured in the accept cycle.
  - In HOLD, `wb_data` updates the held operand in place.
  - rs1 and rs2 are forwarded independently.
  - If rs1 equals rs2, both operands take the same value.
- **Index 0:** the operand is always 0 and is never forwarded, regardless of `rf_r*_read` or `wb_rd`.
- **Reset mid-operation:**
  - Any in-flight request is dropped and the state returns to IDLE.
  - `out_valid`=0, `out_op1`/`out_op2`=0, `out_tag`=0, `rf_r_en`=0, `rf_r1`/`rf_r2`=0.

## Timing
- Latency from accept to `out_valid` is 2 cycles.
- Peak throughput is 1 request per 2 cycles.
- `rf_r_en` is high only in the accept cycle, or in RETRY when bypass is disabled.
- All outputs except `in_ready` and `rf_*` are registered.
- Without bypass:
  - A collision in the accept cycle or the READ cycle sends the FSM to RETRY instead of HOLD.
  - RETRY re-asserts `rf_r_en` with the latched addresses, then returns to READ. This repeats until READ completes with no collision.
  - Each retry adds 2 cycles.
  - In HOLD with no bypass, a collision drops `out_valid` and enters RETRY.

## Configuration
- `OPERAND_FETCH_BYPASS_EN` defined: writeback forwarding as described above; no RETRY state exists.
- `OPERAND_FETCH_BYPASS_EN` undefined: no forwarding datapath; collisions are resolved by re-reading through RETRY. Operand values are identical in both builds; only timing differs.

## Structure
- Shared package `regfile_pkg` holds:
  - `XLEN`
  - `REG_ADDR_W`=5
  - the `REG_ZERO` constant
  - the FSM state enum type `opf_state_t`
- Sub-module `operand_fwd_slot`: one per operand, two instances. Each holds index, value, and pending-forward flag, and performs the collision compare and update.

## Test plan
- **Back-to-back requests:** reg x5=0x11, x6=0x22. Request rs1=5, rs2=6 with `out_ready`=1 → `out_op1`=0x11, `out_op2`=0x22 two cycles after accept. A second request accepted on the handshake cycle follows 2 cycles later.
- **Write in accept cycle:** `wb_en`=1, `wb_rd`=5, `wb_data`=0xAB in the accept cycle of rs1=5 → `out_op1`=0xAB. Latency is 2 with bypass and 4 without.
- **Write in READ and HOLD:** write x6=0x1 in READ, then x6=0x2 in HOLD with `out_ready`=0 → `out_op2` reads 0x1, then 0x2. `out_tag` is unchanged throughout.
- **Index 0:** rs1=0, rs2=0, with `wb_en` to rd=0 and data 0xFFFF_FFFF → both operands are 0.
- **Duplicate index:** rs1=rs2=7 with a collision on x7=0x55 → both operands are 0x55.
- **Reset mid-operation:** `rst_n` low during READ → next cycle `out_valid`=0, `rf_r_en`=0, operands 0. The first request after reset completes normally.
